control_pipe_unit: RTL and testbench
====================================

// Module: control_pipe_unit
// PURPOSE
//  Parametrised successor of the main control decoder. Decodes the ID-stage opcode into a control bundle,
//  registers it into the ID/EX stage and handles pipeline hazards.
//  - Load-use stall, branch/jump flush and external freeze, with bubble insertion.
//  - Optional extended ISA (immediates, BNE, J, JAL). Sits between the IF/ID register and the EX stage.
// PARAMETERS
//  NB_OPCODE  6  opcode width
//  NB_REG     5  register-specifier width
//  NB_ALUOP   3  ALUOp width; 3 is the minimum when EXT_ISA=1
//  EXT_ISA    1  1: ADDI/ANDI/ORI/SLTI/LUI/BNE/J/JAL are legal; 0: only R/LW/SW/BEQ are legal
// PORTS
//  i_clk           in   1          clock, rising edge
//  i_rst_n         in   1          asynchronous active-low reset
//  i_opcode        in   NB_OPCODE  opcode of the instruction in IF/ID
//  i_id_rs         in   NB_REG     rs of the instruction in IF/ID
//  i_id_rt         in   NB_REG     rt of the instruction in IF/ID
//  i_branch_taken  in   1          branch resolved taken (EX/MEM), one-cycle pulse
//  i_freeze        in   1          external freeze (debug unit)
//  i_illegal_clr   in   1          clears o_illegal
//  o_pc_write      out  1          PC update enable (combinational)
//  o_ifid_write    out  1          IF/ID load enable (combinational)
//  o_ifid_flush    out  1          IF/ID clear (combinational)
//  o_jump          out  1          J/JAL in ID; PC takes the jump target (combinational)
//  o_ex_RegDst     out  2          00 rt, 01 rd, 10 $31 (registered)
//  o_ex_ALUOp      out  NB_ALUOP   000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt, 110 lui (registered)
//  o_ex_ALUSrc     out  1          registered ID/EX control
//  o_ex_Branch     out  1          registered ID/EX control
//  o_ex_BranchNe   out  1          registered ID/EX control
//  o_ex_MemRead    out  1          registered ID/EX control
//  o_ex_MemWrite   out  1          registered ID/EX control
//  o_ex_RegWrite   out  1          registered ID/EX control
//  o_ex_MemtoReg   out  1          registered ID/EX control
//  o_ex_rt         out  NB_REG     rt carried in ID/EX for hazard detection
//  o_illegal       out  1          sticky illegal-opcode flag (registered)
// BEHAVIOUR
//  Reset: every registered output is 0 (ID/EX holds a bubble); o_illegal is 0.
//  Decode:
//   - Combinational from i_opcode; the bundle appears on o_ex_* one cycle after ID.
//   - R: RegDst=01, RegWrite, ALUOp=010.  LW: ALUSrc, MemRead, MemtoReg, RegWrite, ALUOp=000.
//   - SW: ALUSrc, MemWrite, ALUOp=000.  BEQ: Branch, ALUOp=001.  BNE: BranchNe, ALUOp=001.
//   - ADDI/ANDI/ORI/SLTI/LUI: ALUSrc, RegWrite, RegDst=00; ALUOp=000/011/100/101/110.
//   - J: o_jump only.  JAL: o_jump, RegWrite, RegDst=10, ALUOp=000.
//  Load-use:
//   - Condition: o_ex_MemRead && o_ex_rt!=0 && (o_ex_rt==i_id_rs || o_ex_rt==i_id_rt).
//   - Action: o_pc_write=0, o_ifid_write=0, a bubble is loaded into ID/EX.
//   - Lasts exactly one cycle, because the bubble clears MemRead.
//  Branch (i_branch_taken=1): o_ifid_flush=1, bubble into ID/EX, o_pc_write=1.
//  Jump (o_jump=1 in ID, no branch/freeze): o_ifid_flush=1; the J/JAL bundle itself enters ID/EX.
//  Priority: freeze > branch_taken > load-use > jump > normal.
//   - A jump sitting in ID during a load-use stall is not flushed and has no effect (o_jump masked).
//  Freeze: ID/EX holds its contents; o_pc_write=0, o_ifid_write=0, o_ifid_flush=0, o_jump=0.
//  Illegal opcode (unlisted, or ext opcode with EXT_ISA=0):
//   - A bubble is loaded instead of the bundle.
//   - o_illegal is set on the next edge and stays set until i_illegal_clr (set wins if both occur).
//  Reset asserted mid-operation clears ID/EX and o_illegal immediately (asynchronous).
// STRUCTURE
//  Package control_pkg holds:
//   - opcode localparams (RFORMAT 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101,
//     ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, LUI 001111, J 000010, JAL 000011);
//   - the ALUOp and RegDst codes;
//   - the packed control-bundle struct.
//  Sub-module control_decoder: purely combinational, opcode -> bundle + illegal.
//  Top level: hazard priority logic and the ID/EX register.
// TESTING
//  1. Reset, then LW (100011) in ID -> next cycle MemRead=1 MemtoReg=1 RegWrite=1 ALUSrc=1 ALUOp=000.
//  2. LW rt=5 in EX, R-type with rs=5 in ID -> pc_write=0, ifid_write=0 for one cycle, then bubble in EX.
//     Same test with rt=0 -> no stall.
//  3. i_branch_taken=1 while load-use is also true -> ifid_flush=1, pc_write=1, bubble in ID/EX.
//  4. JAL (000011) in ID -> o_jump=1, ifid_flush=1; next cycle RegDst=10, RegWrite=1.
//  5. EXT_ISA=0, ADDI (001000) -> bubble, o_illegal=1 until i_illegal_clr. Then opcode 111111 -> o_illegal set again.
//  6. i_freeze=1 for 3 cycles with SW in ID/EX -> o_ex_MemWrite stays 1, no PC/IF/ID writes.
//     Then i_rst_n=0 mid-freeze -> all o_ex_*=0 immediately.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the control pipe unit: opcodes, ALU/RegDst codes and
// the packed control bundle carried through the ID/EX stage.
package control_pkg;

    localparam logic [5:0] OP_RFORMAT = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_SLT   = 3'b101,
        ALU_LUI   = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        REGDST_RT = 2'b00,
        REGDST_RD = 2'b01,
        REGDST_RA = 2'b10
    } reg_dst_e;

    typedef struct packed {
        reg_dst_e reg_dst;
        alu_op_e  alu_op;
        logic     alu_src;
        logic     branch;
        logic     branch_ne;
        logic     mem_read;
        logic     mem_write;
        logic     reg_write;
        logic     mem_to_reg;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/control_decoder.sv
// Purely combinational main decoder: opcode -> control bundle, jump request and
// illegal-opcode indication. Illegal opcodes decode to a bubble.
module control_decoder
    import control_pkg::*;
#(
    parameter int NB_OPCODE = 6,
    parameter int EXT_ISA   = 1
) (
    input  logic [NB_OPCODE-1:0] i_opcode,
    output ctrl_bundle_t         o_bundle,
    output logic                 o_jump,
    output logic                 o_illegal
);

    logic w_ext;

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        o_bundle  = CTRL_BUBBLE;
        o_jump    = 1'b0;
        o_illegal = 1'b0;
        w_ext     = 1'b0;
        case (i_opcode)
            NB_OPCODE'(OP_RFORMAT): begin
                o_bundle.reg_dst   = REGDST_RD;
                o_bundle.reg_write = 1'b1;
                o_bundle.alu_op    = ALU_FUNCT;
            end
            NB_OPCODE'(OP_LW): begin
                o_bundle.alu_src    = 1'b1;
                o_bundle.mem_read   = 1'b1;
                o_bundle.mem_to_reg = 1'b1;
                o_bundle.reg_write  = 1'b1;
            end
            NB_OPCODE'(OP_SW): begin
                o_bundle.alu_src   = 1'b1;
                o_bundle.mem_write = 1'b1;
            end
            NB_OPCODE'(OP_BEQ): begin
                o_bundle.branch = 1'b1;
                o_bundle.alu_op = ALU_SUB;
            end
            NB_OPCODE'(OP_BNE): begin
                w_ext              = 1'b1;
                o_bundle.branch_ne = 1'b1;
                o_bundle.alu_op    = ALU_SUB;
            end
            NB_OPCODE'(OP_ADDI), NB_OPCODE'(OP_ANDI), NB_OPCODE'(OP_ORI),
            NB_OPCODE'(OP_SLTI), NB_OPCODE'(OP_LUI): begin
                w_ext              = 1'b1;
                o_bundle.alu_src   = 1'b1;
                o_bundle.reg_write = 1'b1;
                o_bundle.reg_dst   = REGDST_RT;
                if (i_opcode == NB_OPCODE'(OP_ANDI))      o_bundle.alu_op = ALU_AND;
                else if (i_opcode == NB_OPCODE'(OP_ORI))  o_bundle.alu_op = ALU_OR;
                else if (i_opcode == NB_OPCODE'(OP_SLTI)) o_bundle.alu_op = ALU_SLT;
                else if (i_opcode == NB_OPCODE'(OP_LUI))  o_bundle.alu_op = ALU_LUI;
                else                                      o_bundle.alu_op = ALU_ADD;
            end
            NB_OPCODE'(OP_J): begin
                w_ext  = 1'b1;
                o_jump = 1'b1;
            end
            NB_OPCODE'(OP_JAL): begin
                w_ext              = 1'b1;
                o_jump             = 1'b1;
                o_bundle.reg_write = 1'b1;
                o_bundle.reg_dst   = REGDST_RA;
            end
            default: o_illegal = 1'b1;
        endcase

        // Extended opcodes become illegal bubbles on a base-ISA build.
        if (w_ext && (EXT_ISA == 0)) begin
            o_bundle  = CTRL_BUBBLE;
            o_jump    = 1'b0;
            o_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/control_pipe_unit.sv
// ID-stage control: decodes the opcode, resolves freeze/branch/load-use/jump
// hazards in priority order and registers the control bundle into ID/EX.
module control_pipe_unit
    import control_pkg::*;
#(
    parameter int NB_OPCODE = 6,
    parameter int NB_REG    = 5,
    parameter int NB_ALUOP  = 3,
    parameter int EXT_ISA   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NB_OPCODE-1:0] i_opcode,
    input  logic [NB_REG-1:0]    i_id_rs,
    input  logic [NB_REG-1:0]    i_id_rt,
    input  logic                 i_branch_taken,
    input  logic                 i_freeze,
    input  logic                 i_illegal_clr,
    output logic                 o_pc_write,
    output logic                 o_ifid_write,
    output logic                 o_ifid_flush,
    output logic                 o_jump,
    output logic [1:0]           o_ex_RegDst,
    output logic [NB_ALUOP-1:0]  o_ex_ALUOp,
    output logic                 o_ex_ALUSrc,
    output logic                 o_ex_Branch,
    output logic                 o_ex_BranchNe,
    output logic                 o_ex_MemRead,
    output logic                 o_ex_MemWrite,
    output logic                 o_ex_RegWrite,
    output logic                 o_ex_MemtoReg,
    output logic [NB_REG-1:0]    o_ex_rt,
    output logic                 o_illegal
);

    ctrl_bundle_t        w_dec_bundle;
    logic                w_dec_jump;
    logic                w_dec_illegal;
    logic                w_load_use;
    logic                w_idex_load;
    logic                w_set_illegal;
    ctrl_bundle_t        w_next_bundle;
    logic [NB_REG-1:0]   w_next_rt;

    ctrl_bundle_t        r_bundle;
    logic [NB_REG-1:0]   r_ex_rt;
    logic                r_illegal;

    control_decoder #(
        .NB_OPCODE (NB_OPCODE),
        .EXT_ISA   (EXT_ISA)
    ) u_decoder (
        .i_opcode  (i_opcode),
        .o_bundle  (w_dec_bundle),
        .o_jump    (w_dec_jump),
        .o_illegal (w_dec_illegal)
    );

    assign w_load_use = r_bundle.mem_read && (r_ex_rt != '0) &&
                        ((r_ex_rt == i_id_rs) || (r_ex_rt == i_id_rt));

    always_comb begin
        o_pc_write    = 1'b1;
        o_ifid_write  = 1'b1;
        o_ifid_flush  = 1'b0;
        o_jump        = 1'b0;
        w_idex_load   = 1'b1;
        w_set_illegal = 1'b0;
        w_next_bundle = CTRL_BUBBLE;
        w_next_rt     = '0;
        if (i_freeze) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            w_idex_load  = 1'b0;
        end else if (i_branch_taken) begin
            o_ifid_flush = 1'b1;
        end else if (w_load_use) begin
            // The stalled instruction is re-presented next cycle, so it is not flagged yet.
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end else begin
            o_jump        = w_dec_jump;
            o_ifid_flush  = w_dec_jump;
            w_set_illegal = w_dec_illegal;
            if (!w_dec_illegal) begin
                w_next_bundle = w_dec_bundle;
                w_next_rt     = i_id_rt;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments and an asynchronous reset in the sensitivity list.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bundle <= CTRL_BUBBLE;
            r_ex_rt  <= '0;
        end else if (w_idex_load) begin
            r_bundle <= w_next_bundle;
            r_ex_rt  <= w_next_rt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)            r_illegal <= 1'b0;
        else if (w_set_illegal)  r_illegal <= 1'b1;
        else if (i_illegal_clr)  r_illegal <= 1'b0;
    end

    assign o_ex_RegDst   = r_bundle.reg_dst;
    assign o_ex_ALUOp    = NB_ALUOP'(r_bundle.alu_op);
    assign o_ex_ALUSrc   = r_bundle.alu_src;
    assign o_ex_Branch   = r_bundle.branch;
    assign o_ex_BranchNe = r_bundle.branch_ne;
    assign o_ex_MemRead  = r_bundle.mem_read;
    assign o_ex_MemWrite = r_bundle.mem_write;
    assign o_ex_RegWrite = r_bundle.reg_write;
    assign o_ex_MemtoReg = r_bundle.mem_to_reg;
    assign o_ex_rt       = r_ex_rt;
    assign o_illegal     = r_illegal;

endmodule

// File: tb/tb_control_pipe_unit.sv
// Directed bench for control_pipe_unit: an extended-ISA instance and a base-ISA
// instance share stimulus; expected bundles are hand-written constants.
module tb_control_pipe_unit;

    // {RegDst[1:0], ALUOp[2:0], ALUSrc, Branch, BranchNe, MemRead, MemWrite, RegWrite, MemtoReg}
    localparam logic [11:0] EX_LW   = 12'b00_000_1_0_0_1_0_1_1;
    localparam logic [11:0] EX_R    = 12'b01_010_0_0_0_0_0_1_0;
    localparam logic [11:0] EX_SW   = 12'b00_000_1_0_0_0_1_0_0;
    localparam logic [11:0] EX_JAL  = 12'b10_000_0_0_0_0_0_1_0;
    localparam logic [11:0] EX_ADDI = 12'b00_000_1_0_0_0_0_1_0;

    logic       i_clk, i_rst_n;
    logic [5:0] i_opcode;
    logic [4:0] i_id_rs, i_id_rt;
    logic       i_branch_taken, i_freeze, i_illegal_clr;

    logic       pc_write, ifid_write, ifid_flush, jump, illegal;
    logic [1:0] ex_regdst;
    logic [2:0] ex_aluop;
    logic       ex_alusrc, ex_branch, ex_branchne, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
    logic [4:0] ex_rt;

    logic       b_pc_write, b_ifid_write, b_ifid_flush, b_jump, b_illegal;
    logic [1:0] b_ex_regdst;
    logic [2:0] b_ex_aluop;
    logic       b_ex_alusrc, b_ex_branch, b_ex_branchne, b_ex_memread, b_ex_memwrite, b_ex_regwrite, b_ex_memtoreg;
    logic [4:0] b_ex_rt;

    logic [11:0] ex_vec, b_ex_vec;
    assign ex_vec   = {ex_regdst, ex_aluop, ex_alusrc, ex_branch, ex_branchne,
                       ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg};
    assign b_ex_vec = {b_ex_regdst, b_ex_aluop, b_ex_alusrc, b_ex_branch, b_ex_branchne,
                       b_ex_memread, b_ex_memwrite, b_ex_regwrite, b_ex_memtoreg};

    int vectors = 0;
    int miscompares = 0;

    control_pipe_unit #(.EXT_ISA(1)) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
        .i_branch_taken(i_branch_taken), .i_freeze(i_freeze), .i_illegal_clr(i_illegal_clr),
        .o_pc_write(pc_write), .o_ifid_write(ifid_write), .o_ifid_flush(ifid_flush), .o_jump(jump),
        .o_ex_RegDst(ex_regdst), .o_ex_ALUOp(ex_aluop), .o_ex_ALUSrc(ex_alusrc), .o_ex_Branch(ex_branch),
        .o_ex_BranchNe(ex_branchne), .o_ex_MemRead(ex_memread), .o_ex_MemWrite(ex_memwrite),
        .o_ex_RegWrite(ex_regwrite), .o_ex_MemtoReg(ex_memtoreg), .o_ex_rt(ex_rt), .o_illegal(illegal)
    );

    control_pipe_unit #(.EXT_ISA(0)) u_dut_base (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
        .i_branch_taken(i_branch_taken), .i_freeze(i_freeze), .i_illegal_clr(i_illegal_clr),
        .o_pc_write(b_pc_write), .o_ifid_write(b_ifid_write), .o_ifid_flush(b_ifid_flush), .o_jump(b_jump),
        .o_ex_RegDst(b_ex_regdst), .o_ex_ALUOp(b_ex_aluop), .o_ex_ALUSrc(b_ex_alusrc), .o_ex_Branch(b_ex_branch),
        .o_ex_BranchNe(b_ex_branchne), .o_ex_MemRead(b_ex_memread), .o_ex_MemWrite(b_ex_memwrite),
        .o_ex_RegWrite(b_ex_regwrite), .o_ex_MemtoReg(b_ex_memtoreg), .o_ex_rt(b_ex_rt), .o_illegal(b_illegal)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within its time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        i_opcode = op;
        i_id_rs  = rs;
        i_id_rt  = rt;
    endtask

    logic [5:0]  dec_ops  [4] = '{6'b000100, 6'b000101, 6'b001101, 6'b001111};
    logic [11:0] dec_exps [4] = '{12'b00_001_0_1_0_0_0_0_0, 12'b00_001_0_0_1_0_0_0_0,
                                  12'b00_100_1_0_0_0_0_1_0, 12'b00_110_1_0_0_0_0_1_0};

    initial begin
        i_rst_n = 1'b0; i_branch_taken = 1'b0; i_freeze = 1'b0; i_illegal_clr = 1'b0;
        set_id(6'b100011, 5'd1, 5'd5);
        #3;
        check("reset_ex_bundle", 16'(ex_vec), 16'h0);
        check("reset_illegal", 16'(illegal), 16'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;

        // 1: LW decode
        check("lw_pc_write", 16'(pc_write), 16'h1);
        check("lw_ifid_write", 16'(ifid_write), 16'h1);
        tick();
        check("lw_ex_bundle", 16'(ex_vec), 16'(EX_LW));
        check("lw_ex_rt", 16'(ex_rt), 16'd5);

        // 2: load-use stall, then rt=0 case
        set_id(6'b000000, 5'd5, 5'd2);
        #1;
        check("lu_pc_write", 16'(pc_write), 16'h0);
        check("lu_ifid_write", 16'(ifid_write), 16'h0);
        check("lu_ifid_flush", 16'(ifid_flush), 16'h0);
        tick();
        check("lu_bubble", 16'(ex_vec), 16'h0);
        check("lu_release_pc_write", 16'(pc_write), 16'h1);
        tick();
        check("lu_r_bundle", 16'(ex_vec), 16'(EX_R));
        set_id(6'b100011, 5'd1, 5'd0);
        tick();
        set_id(6'b000000, 5'd0, 5'd0);
        #1;
        check("rt0_no_stall_pc", 16'(pc_write), 16'h1);
        check("rt0_no_stall_ifid", 16'(ifid_write), 16'h1);
        tick();
        check("rt0_r_bundle", 16'(ex_vec), 16'(EX_R));

        // 3: branch taken overrides a simultaneous load-use
        set_id(6'b100011, 5'd1, 5'd7);
        tick();
        set_id(6'b000000, 5'd7, 5'd3);
        i_branch_taken = 1'b1;
        #1;
        check("br_ifid_flush", 16'(ifid_flush), 16'h1);
        check("br_pc_write", 16'(pc_write), 16'h1);
        tick();
        i_branch_taken = 1'b0;
        check("br_bubble", 16'(ex_vec), 16'h0);

        // 4: jump masked under load-use, then JAL
        set_id(6'b100011, 5'd1, 5'd3);
        tick();
        set_id(6'b000010, 5'd3, 5'd0);
        #1;
        check("j_masked_jump", 16'(jump), 16'h0);
        check("j_masked_flush", 16'(ifid_flush), 16'h0);
        tick();
        set_id(6'b000011, 5'd0, 5'd0);
        #1;
        check("jal_jump", 16'(jump), 16'h1);
        check("jal_flush", 16'(ifid_flush), 16'h1);
        check("jal_pc_write", 16'(pc_write), 16'h1);
        tick();
        check("jal_bundle", 16'(ex_vec), 16'(EX_JAL));
        for (int k = 0; k < 4; k++) begin
            set_id(dec_ops[k], 5'd0, 5'd0);
            tick();
            check($sformatf("decode_%02h", dec_ops[k]), 16'(ex_vec), 16'(dec_exps[k]));
        end

        // 5: ADDI illegal only on the base-ISA build; sticky flag, set wins over clear
        set_id(6'b000000, 5'd0, 5'd0);
        i_illegal_clr = 1'b1;
        tick();
        i_illegal_clr = 1'b0;
        check("base_clr", 16'(b_illegal), 16'h0);
        set_id(6'b001000, 5'd0, 5'd0);
        tick();
        check("base_addi_bubble", 16'(b_ex_vec), 16'h0);
        check("base_addi_illegal", 16'(b_illegal), 16'h1);
        check("ext_addi_bundle", 16'(ex_vec), 16'(EX_ADDI));
        check("ext_addi_legal", 16'(illegal), 16'h0);
        set_id(6'b000000, 5'd0, 5'd0);
        tick();
        check("base_illegal_sticky", 16'(b_illegal), 16'h1);
        set_id(6'b111111, 5'd0, 5'd0);
        i_illegal_clr = 1'b1;
        tick();
        check("set_wins_base", 16'(b_illegal), 16'h1);
        check("set_wins_ext", 16'(illegal), 16'h1);
        check("op3f_bubble", 16'(ex_vec), 16'h0);
        set_id(6'b000000, 5'd0, 5'd0);
        tick();
        check("clr_base", 16'(b_illegal), 16'h0);
        check("clr_ext", 16'(illegal), 16'h0);
        i_illegal_clr = 1'b0;
        set_id(6'b111111, 5'd0, 5'd0);
        tick();
        check("op3f_set_again_base", 16'(b_illegal), 16'h1);
        check("op3f_set_again_ext", 16'(illegal), 16'h1);

        // 6: freeze holds SW in ID/EX, then asynchronous reset mid-freeze
        set_id(6'b101011, 5'd0, 5'd0);
        tick();
        check("sw_bundle", 16'(ex_vec), 16'(EX_SW));
        set_id(6'b000010, 5'd0, 5'd0);
        i_freeze = 1'b1;
        #1;
        check("frz_pc_write", 16'(pc_write), 16'h0);
        check("frz_ifid_write", 16'(ifid_write), 16'h0);
        check("frz_ifid_flush", 16'(ifid_flush), 16'h0);
        check("frz_jump", 16'(jump), 16'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("frz_hold_memwrite_%0d", c), 16'(ex_memwrite), 16'h1);
            check($sformatf("frz_hold_bundle_%0d", c), 16'(ex_vec), 16'(EX_SW));
        end
        check("frz_illegal_kept", 16'(illegal), 16'h1);
        i_rst_n = 1'b0;
        #1;
        check("async_rst_bundle", 16'(ex_vec), 16'h0);
        check("async_rst_illegal", 16'(illegal), 16'h0);
        check("async_rst_base_illegal", 16'(b_illegal), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
